reset_sequencer: RTL and testbench
==================================

# reset_sequencer

Multi-channel power-on/soft reset sequencer. Holds every channel reset asserted for a programmable hold time, then releases the channels one at a time, in index order, with a programmable inter-stage gap. Any sequence can be restarted by the synchronous reset or by a reset-request input. Sits at the top of the clock domain and drives the resets of downstream subsystems (PLL-dependent logic, memory controller, user logic).

## Interface
- `CLOCK_HZ`, 48000000, clock frequency in Hz
- `TIME_NS`, 1000000, initial hold time before channel 0 is released
- `STAGE_NS`, 10000, gap between consecutive channel releases
- `CHANNELS`, 4, number of reset outputs; legal range 1..255

- `clk`  in  1  system clock; single clock domain
- `rst`  in  1  reset; synchronous, active-high; restarts the sequence
- `req_in`  in  1  active-high reset request; restarts the sequence
- `reset_out`  out  CHANNELS  per-channel reset, active-high
- `busy`  out  1  high while the sequence is not complete
- `stage_out`  out  8  number of channels released so far (0..CHANNELS), zero-extended
- `done_pulse`  out  1  one-cycle strobe when the last channel is released

## Operation
- Cycle counts:
  - HOLD_CYCLES = max(1, TIME_NS*CLOCK_HZ/10^9)
  - STAGE_CYCLES = max(1, STAGE_NS*CLOCK_HZ/10^9)
  - Computed with 64-bit intermediate arithmetic and truncated toward zero.
- Down-counter width is $clog2(max(HOLD_CYCLES, STAGE_CYCLES)+1), with a minimum of 1 bit.
- States: HOLD, RELEASE, RUN.
- Restart condition is `rst` or the effective `req` being high at a clock edge. Either one forces, at that edge:
  - state = HOLD
  - counter = HOLD_CYCLES-1
  - `reset_out` = all ones
  - `stage_out` = 0
  - `done_pulse` = 0
- Restart has priority over every other transition. While it is held, the block stays in HOLD with the counter reloaded, so hold time is measured from its deassertion.
- HOLD:
  - counter != 0: decrement.
  - counter == 0: clear `reset_out[0]`, set `stage_out` = 1, load STAGE_CYCLES-1.
  - Then go to RELEASE, or go to RUN with `done_pulse` if CHANNELS == 1.
- RELEASE:
  - counter != 0: decrement.
  - counter == 0: clear `reset_out[stage_out]`, increment `stage_out`, reload STAGE_CYCLES-1.
  - If this was channel CHANNELS-1, go to RUN and assert `done_pulse` for one cycle.
- RUN: outputs are static and the counter is idle. Only a restart leaves RUN.
- `busy` = (state != RUN); it is decoded combinationally from the registered state.
- Power-up: initial values equal the state just after a restart edge. The block sequences with no `rst` ever applied.
- Released channels are never reasserted individually. Reassertion is always all channels at once.

## Timing
- Let k0 be the last edge at which restart is high.
- Channel i deasserts at edge k0 + HOLD_CYCLES + i*STAGE_CYCLES.
- `done_pulse` is high only during the cycle following edge k0 + HOLD_CYCLES + (CHANNELS-1)*STAGE_CYCLES.
- At power-up with no restart, treat k0 = -1, where edge 0 is the first clock edge.
- Restart-to-reassert latency is zero cycles: outputs are high immediately after the sampling edge.
- A restart in the same cycle as a scheduled release wins; no channel is released.
- All outputs are registered except `busy`.

## Configuration
- `RESET_SEQ_REQ_SYNC_EN` defined:
  - `req_in` passes through a 2-flop synchronizer; effective `req` lags `req_in` by 2 edges.
  - The synchronizer flops initialise to 0 and are cleared by `rst`.
  - `req_in` may be asynchronous.
- Not defined:
  - effective `req` = `req_in` directly, with zero added latency.
  - `req_in` must be synchronous to `clk`.
- `rst` is never synchronized in either configuration.

## Test plan
All scenarios use CLOCK_HZ=100000000, TIME_NS=100, STAGE_NS=30, CHANNELS=3, giving HOLD_CYCLES=10 and STAGE_CYCLES=3.

1. `rst` high edges 0..4, then low:
   - `reset_out`=111 through edge 13; 110 at edge 14; 100 at edge 17; 000 at edge 20.
   - `stage_out` reads 1, 2, 3 at those edges.
   - `done_pulse` high only after edge 20; `busy` low after edge 20.
2. No sync macro, one-cycle `req_in` at edge 30 in RUN:
   - `reset_out`=111 and `busy`=1 after edge 30.
   - Releases at edges 40, 43, 46.
3. `req_in` high edges 15..19, during RELEASE with `stage_out`=1:
   - All channels reassert at edge 15; `stage_out`=0.
   - Releases at edges 29, 32, 35; no `done_pulse` before edge 35.
4. Restart colliding with a release: `req_in` high only at edge 17, the scheduled release of channel 1.
   - `reset_out` stays 111; `stage_out`=0.
   - Channel 0 releases at edge 27.
5. No `rst` applied (power-up):
   - Channel 0 releases at edge 9, channel 1 at 12, channel 2 at 15.
   - `done_pulse` after edge 15.
6. With `RESET_SEQ_REQ_SYNC_EN`, `req_in` pulse at edge 30:
   - `reset_out` reasserts at edge 32.
   - Channel 0 releases at edge 42.

Source files
------------

// File: rtl/reset_sequencer.sv
// reset_sequencer: multi-channel power-on / soft reset sequencer.
// All channel resets are held for a programmable time, then released one
// at a time in index order with a programmable gap between releases.
// `rst` or the effective request restarts the whole sequence at once.
// Optional build macro: RESET_SEQ_REQ_SYNC_EN -- when defined, req_in is
// passed through a 2-flop synchronizer (2 edges of added latency) so it
// may be driven asynchronously; when undefined req_in is used directly.
module reset_sequencer #(
  parameter longint unsigned CLOCK_HZ = 64'd48000000,
  parameter longint unsigned TIME_NS  = 64'd1000000,
  parameter longint unsigned STAGE_NS = 64'd10000,
  parameter int              CHANNELS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_in,
  output logic [CHANNELS-1:0] reset_out,
  output logic                busy,
  output logic [7:0]          stage_out,
  output logic                done_pulse
);

  // Cycle counts derived from the requested times, truncated toward zero
  // with 64-bit arithmetic and clamped to at least one cycle.
  localparam longint unsigned HOLD_RAW    = (TIME_NS * CLOCK_HZ) / 64'd1000000000;
  localparam longint unsigned STAGE_RAW   = (STAGE_NS * CLOCK_HZ) / 64'd1000000000;
  localparam longint unsigned HOLD_CYCLES = (HOLD_RAW == 64'd0) ? 64'd1 : HOLD_RAW;
  localparam longint unsigned STAGE_CYCLES = (STAGE_RAW == 64'd0) ? 64'd1 : STAGE_RAW;
  localparam longint unsigned CNT_MAX =
    (HOLD_CYCLES > STAGE_CYCLES) ? HOLD_CYCLES : STAGE_CYCLES;

  // Down-counter only needs to reach the larger of the two reload values.
  localparam int CNT_W_RAW = $clog2(CNT_MAX + 64'd1);
  localparam int CNT_W     = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;

  localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYCLES - 64'd1);
  localparam logic [CNT_W-1:0] STAGE_LOAD = CNT_W'(STAGE_CYCLES - 64'd1);
  localparam logic [7:0]       LAST_STAGE = 8'(CHANNELS - 1);

  // stage_out is 8 bits wide, so the channel count must fit in it.
  generate
    if (CHANNELS < 1 || CHANNELS > 255) begin : g_bad_channels
      $error("reset_sequencer: CHANNELS must be in 1..255");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_HOLD    = 2'd0,
    S_RELEASE = 2'd1,
    S_RUN     = 2'd2
  } state_t;

  // Registered state. Declaration values give the power-up condition,
  // which matches the state right after a restart edge, so the block
  // sequences correctly even if rst is never asserted.
  state_t               r_state   = S_HOLD;
  logic [CNT_W-1:0]     r_count   = HOLD_LOAD;
  logic [CHANNELS-1:0]  r_reset   = '1;
  logic [7:0]           r_stage   = 8'd0;
  logic                 r_done    = 1'b0;

  state_t               w_state_next;
  logic [CNT_W-1:0]     w_count_next;
  logic [CHANNELS-1:0]  w_reset_next;
  logic [7:0]           w_stage_next;
  logic                 w_done_next;

  logic                 w_req;
  logic                 w_restart;
  logic                 w_count_zero;
  logic [CHANNELS-1:0]  w_stage_sel;

`ifdef RESET_SEQ_REQ_SYNC_EN
  // Synchronizer flops start cleared so an undriven request at power-up
  // cannot spuriously restart the sequence.
  logic r_req_meta = 1'b0;
  logic r_req_sync = 1'b0;

  // Two-flop synchronizer for the request input, cleared by rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_req_meta <= 1'b0;
      r_req_sync <= 1'b0;
    end else begin
      r_req_meta <= req_in;
      r_req_sync <= r_req_meta;
    end
  end

  assign w_req = r_req_sync;
`else
  // Request is already synchronous to clk; use it with no added latency.
  assign w_req = req_in;
`endif

  assign w_restart    = rst | w_req;
  assign w_count_zero = (r_count == '0);

  // One-hot select of the channel that the next release will clear; the
  // released-channel count doubles as the index of the next channel.
  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_stage_sel
      assign w_stage_sel[gi] = (r_stage == 8'(gi));
    end
  endgenerate

  // State register: restart has priority over every other transition.
  always_ff @(posedge clk) begin
    if (w_restart) begin
      r_state <= S_HOLD;
      r_count <= HOLD_LOAD;
      r_reset <= '1;
      r_stage <= 8'd0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
      r_reset <= w_reset_next;
      r_stage <= w_stage_next;
      r_done  <= w_done_next;
    end
  end

  // Next-state and next-output decode for the release sequence.
  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    w_reset_next = r_reset;
    w_stage_next = r_stage;
    w_done_next  = 1'b0;

    case (r_state)
      S_HOLD: begin
        if (!w_count_zero) begin
          w_count_next = r_count - CNT_W'(1);
        end else begin
          w_reset_next[0] = 1'b0;
          w_stage_next    = 8'd1;
          w_count_next    = STAGE_LOAD;
          if (CHANNELS == 1) begin
            w_state_next = S_RUN;
            w_done_next  = 1'b1;
          end else begin
            w_state_next = S_RELEASE;
          end
        end
      end

      S_RELEASE: begin
        if (!w_count_zero) begin
          w_count_next = r_count - CNT_W'(1);
        end else begin
          w_reset_next = r_reset & ~w_stage_sel;
          w_stage_next = r_stage + 8'd1;
          w_count_next = STAGE_LOAD;
          if (r_stage == LAST_STAGE) begin
            w_state_next = S_RUN;
            w_done_next  = 1'b1;
          end
        end
      end

      S_RUN: begin
        // Outputs frozen; only a restart leaves this state.
      end

      default: begin
        // Unreachable encoding: fall back to a full restart.
        w_state_next = S_HOLD;
        w_count_next = HOLD_LOAD;
        w_reset_next = '1;
        w_stage_next = 8'd0;
      end
    endcase
  end

  assign reset_out  = r_reset;
  assign stage_out  = r_stage;
  assign done_pulse = r_done;
  assign busy       = (r_state != S_RUN);

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: randomized scoreboard bench for reset_sequencer.
// The reference model works from release timestamps: it remembers the
// last restart edge k0 and derives every output from edge arithmetic.
module tb_reset_sequencer;

  localparam longint unsigned CLK_HZ = 64'd100000000;
  localparam longint unsigned T_NS   = 64'd100;
  localparam longint unsigned S_NS   = 64'd30;
  localparam int CH    = 3;
  localparam int HOLD  = 10;
  localparam int STAGE = 3;
`ifdef RESET_SEQ_REQ_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  bit            clk;
  logic          rst    = 1'b0;
  logic          req_in = 1'b0;
  logic [CH-1:0] reset_out;
  logic          busy;
  logic [7:0]    stage_out;
  logic          done_pulse;

  reset_sequencer #(
    .CLOCK_HZ (CLK_HZ),
    .TIME_NS  (T_NS),
    .STAGE_NS (S_NS),
    .CHANNELS (CH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_in     (req_in),
    .reset_out  (reset_out),
    .busy       (busy),
    .stage_out  (stage_out),
    .done_pulse (done_pulse)
  );

  // Clock: first rising edge (edge 0) at t=5.
  initial begin
    forever begin
      #5 clk = 1'b1;
      #5 clk = 1'b0;
    end
  end

  typedef struct {
    int            n;
    logic [CH-1:0] ro;
    logic [7:0]    st;
    logic          dn;
    logic          bz;
  } exp_t;

  exp_t sb_q[$];
  bit   rst_h[$];
  bit   req_h[$];
  int   edge_cnt = 0;
  int   model_k0 = -1;
  int   txn_id   = 0;
  int   checks   = 0;
  int   failures = 0;

  // Effective request seen by the sequencer at edge n.
  function automatic bit eff_req(input int n);
    if (LAT == 0) return req_h[n];
    if (n < 2) return 1'b0;
    return req_h[n-2] && !rst_h[n-2] && !rst_h[n-1];
  endfunction

  // Drive inputs for the upcoming edge and push the expected outputs.
  task automatic step(input bit r, input bit q);
    exp_t e;
    int   d;
    int   rel;
    rst    = r;
    req_in = q;
    rst_h.push_back(r);
    req_h.push_back(q);
    if (r || eff_req(edge_cnt)) model_k0 = edge_cnt;
    d = edge_cnt - model_k0 - HOLD;
    if (d < 0) rel = 0;
    else rel = (d / STAGE + 1 > CH) ? CH : d / STAGE + 1;
    e.n = edge_cnt;
    for (int i = 0; i < CH; i++) e.ro[i] = (i >= rel);
    e.st = 8'(rel);
    e.dn = (d == (CH - 1) * STAGE);
    e.bz = (rel < CH);
    sb_q.push_back(e);
    edge_cnt++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  task automatic txn(input string what, input int len);
    $display("txn %0d edge=%0d %s len=%0d", txn_id, edge_cnt, what, len);
    txn_id++;
  endtask

  // Land an effective request exactly on the scheduled release of channel j.
  task automatic collide(input int j);
    int t;
    int w;
    t = model_k0 + HOLD + j * STAGE;
    w = t - LAT - edge_cnt;
    if (w >= 0) begin
      idle(w);
      step(1'b0, 1'b1);
    end
  endtask

  task automatic cmp(input string name, input int n,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s edge=%0d actual=%0h expected=%0h", name, n, act, exp);
    end
  endtask

  // Monitor: outputs are presented every cycle; compare #1 after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_empty edge_time=%0t actual=0 expected=1", $time);
      end else begin
        e = sb_q.pop_front();
        cmp("reset_out",  e.n, 32'(reset_out),  32'(e.ro));
        cmp("stage_out",  e.n, 32'(stage_out),  32'(e.st));
        cmp("done_pulse", e.n, 32'(done_pulse), 32'(e.dn));
        cmp("busy",       e.n, 32'(busy),       32'(e.bz));
      end
    end
  end

  // Stimulus: directed scenarios first, then randomized phases.
  initial begin
    int sel;
    int len;

    txn("powerup_idle", 25);
    idle(25);

    txn("rst_hold", 5);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    idle(22);

    txn("req_in_run", 1);
    step(1'b0, 1'b1);
    idle(25);

    txn("req_in_release", 5);
    step(1'b1, 1'b0);
    idle(HOLD + 1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1);
    idle(30);

    txn("collide_ch1", 1);
    step(1'b1, 1'b0);
    collide(1);
    idle(25);

    for (int p = 0; p < 80; p++) begin
      sel = int'($urandom_range(0, 4));
      case (sel)
        0: begin
          len = int'($urandom_range(1, 30));
          txn("rand_idle", len);
          idle(len);
        end
        1: begin
          len = int'($urandom_range(1, 4));
          txn("rand_rst", len);
          for (int i = 0; i < len; i++) step(1'b1, 1'b0);
        end
        2: begin
          len = int'($urandom_range(1, 3));
          txn("rand_req", len);
          for (int i = 0; i < len; i++) step(1'b0, 1'b1);
        end
        3: begin
          len = int'($urandom_range(0, CH - 1));
          txn("rand_collide", len);
          step(1'b1, 1'b0);
          collide(len);
        end
        default: begin
          len = int'($urandom_range(1, 6));
          txn("rand_mix", len);
          for (int i = 0; i < len; i++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
      endcase
    end

    txn("final_drain", 40);
    idle(40);

    cmp("sb_drained", edge_cnt, 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
